// File: rtl/reaction_pkg.sv
// Shared constants and types for the reaction-time counter: game state codes and BCD digit type.
package reaction_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_START  = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;
    localparam logic [1:0] ST_HIGH   = 2'b11;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD decade: synchronous clear, increment with 9->0 wrap and carry out to the next decade.
module bcd_digit_counter
    import reaction_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       carry
);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == BCD_NINE) ? '0 : digit + BCD_W'(1);
        end
    end

    assign carry = inc && (digit == BCD_NINE);

endmodule

// File: rtl/reaction_time_counter.sv
// Reaction-time counter: synchronizes game state/Delay, counts ms ticks in BCD with saturation.
// Optional HIGH_SCORE_EN builds the best-score register, compare and New_Best pulse.
module reaction_time_counter
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [1:0]          State,
    input  logic                Delay,
    output logic [4*DIGITS-1:0] Count_BCD,
    output logic [4*DIGITS-1:0] Best_BCD,
    output logic [4*DIGITS-1:0] Display_BCD,
    output logic                Running,
    output logic                New_Best,
    output logic                Overflow
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [1:0]       state_meta;
    logic [1:0]       state_sync;
    logic [1:0]       s_prev;
    logic             delay_meta;
    logic             delay_sync;
    logic [PRE_W-1:0] prescaler;
    logic             start_entry;
    logic             tick;
    logic             all_nine;
    logic             unused_carry;
    logic [DIGITS:0]  inc_chain;
    bcd_digit_t       digit_q [DIGITS];

    // Two-flop synchronizers plus previous synced state for edge detection
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_meta <= ST_IDLE;
            state_sync <= ST_IDLE;
            s_prev     <= ST_IDLE;
            delay_meta <= 1'b0;
            delay_sync <= 1'b0;
        end else begin
            state_meta <= State;
            state_sync <= state_meta;
            s_prev     <= state_sync;
            delay_meta <= Delay;
            delay_sync <= delay_meta;
        end
    end

    assign start_entry = (s_prev != ST_START) && (state_sync == ST_START);
    assign Running     = (state_sync == ST_START) && delay_sync;
    assign tick        = Running && (prescaler == PRE_MAX);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prescaler <= '0;
        end else if (start_entry || !Running || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_q[i] != BCD_NINE) all_nine = 1'b0;
        end
    end

    // Saturate at all nines: the tick is suppressed rather than wrapping the count
    assign inc_chain[0] = tick && !all_nine;
    assign unused_carry = inc_chain[DIGITS];

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_digit_counter u_digit (
            .Clock (Clock),
            .Reset (Reset),
            .clr   (start_entry),
            .inc   (inc_chain[i]),
            .digit (digit_q[i]),
            .carry (inc_chain[i+1])
        );
        assign Count_BCD[4*i +: 4] = digit_q[i];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Overflow <= 1'b0;
        end else if (start_entry) begin
            Overflow <= 1'b0;
        end else if (tick && all_nine) begin
            Overflow <= 1'b1;
        end
    end

`ifdef HIGH_SCORE_EN
    logic                finish_entry;
    logic [4*DIGITS-1:0] best_q;

    assign finish_entry = (s_prev == ST_START) && (state_sync == ST_FINISH);

    // Valid BCD orders like unsigned binary, so a plain compare ranks scores
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            best_q   <= {DIGITS{BCD_NINE}};
            New_Best <= 1'b0;
        end else begin
            New_Best <= 1'b0;
            if (finish_entry && !Overflow && (Count_BCD < best_q)) begin
                best_q   <= Count_BCD;
                New_Best <= 1'b1;
            end
        end
    end

    assign Best_BCD    = best_q;
    assign Display_BCD = (state_sync == ST_HIGH) ? best_q : Count_BCD;
`else
    assign Best_BCD    = '0;
    assign New_Best    = 1'b0;
    assign Display_BCD = Count_BCD;
`endif

endmodule

// File: tb/tb_reaction_time_counter.sv
// Bench for reaction_time_counter: integer-level model checked every cycle plus directed literal checks.
module tb_reaction_time_counter;

`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif
    localparam logic [15:0] BEST_INIT = HS ? 16'h9999 : 16'h0000;
    localparam logic [7:0]  SBEST_INIT = HS ? 8'h99 : 8'h00;

    typedef struct {
        int count;
        int best;
        int phase;
        bit ovf;
        bit nb;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  st;
    logic        dl;
    logic [15:0] cnt, best, disp;
    logic        run, nb, ovf;
    logic [7:0]  s_cnt, s_best, s_disp;
    logic        s_run, s_nb, s_ovf;

    int checks = 0;
    int errors = 0;
    int nb_main = 0;
    int nb_sat = 0;

    reaction_time_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(4)) dut (
        .Clock(clk), .Reset(rst_n), .State(st), .Delay(dl),
        .Count_BCD(cnt), .Best_BCD(best), .Display_BCD(disp),
        .Running(run), .New_Best(nb), .Overflow(ovf)
    );

    // Small instance so saturation is reachable in a short run
    reaction_time_counter #(.CLK_HZ(2), .TICK_HZ(1), .DIGITS(2)) u_sat (
        .Clock(clk), .Reset(rst_n), .State(st), .Delay(dl),
        .Count_BCD(s_cnt), .Best_BCD(s_best), .Display_BCD(s_disp),
        .Running(s_run), .New_Best(s_nb), .Overflow(s_ovf)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mstate_t mreset(input int maxv);
        mstate_t r;
        r.count = 0;
        r.best  = maxv;
        r.phase = 0;
        r.ovf   = 1'b0;
        r.nb    = 1'b0;
        return r;
    endfunction

    // One clock of the game-level rules, using integer counts and a cycle phase
    function automatic mstate_t mstep(input mstate_t m, input int div, input int maxv,
                                      input logic [1:0] s, input logic [1:0] prev, input logic d);
        mstate_t r;
        r = m;
        r.nb = 1'b0;
        if (prev != 2'b01 && s == 2'b01) begin
            r.count = 0;
            r.phase = 0;
            r.ovf   = 1'b0;
        end else if (s == 2'b01 && d) begin
            if (r.phase == div - 1) begin
                r.phase = 0;
                if (r.count == maxv) r.ovf = 1'b1;
                else r.count = r.count + 1;
            end else begin
                r.phase = r.phase + 1;
            end
        end else begin
            r.phase = 0;
        end
        if (HS && prev == 2'b01 && s == 2'b10 && !r.ovf && r.count < r.best) begin
            r.best = r.count;
            r.nb   = 1'b1;
        end
        return r;
    endfunction

    mstate_t    mm, ms;
    logic [1:0] m_sm, m_s, m_prev;
    logic       m_dm, m_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm <= mreset(9999);
            ms <= mreset(99);
            m_sm <= 2'b00; m_s <= 2'b00; m_prev <= 2'b00;
            m_dm <= 1'b0;  m_d <= 1'b0;
        end else begin
            mm <= mstep(mm, 10, 9999, m_s, m_prev, m_d);
            ms <= mstep(ms, 2, 99, m_s, m_prev, m_d);
            m_prev <= m_s; m_s <= m_sm; m_sm <= st;
            m_d <= m_dm;   m_dm <= dl;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("count",    32'(cnt),  32'(to_bcd(mm.count)));
            chk("best",     32'(best), HS ? 32'(to_bcd(mm.best)) : 32'h0);
            chk("display",  32'(disp), (HS && m_s == 2'b11) ? 32'(to_bcd(mm.best)) : 32'(to_bcd(mm.count)));
            chk("running",  32'(run),  32'(m_s == 2'b01 && m_d));
            chk("new_best", 32'(nb),   32'(mm.nb));
            chk("overflow", 32'(ovf),  32'(mm.ovf));
            chk("s_count",  32'(s_cnt),  32'(8'(to_bcd(ms.count))));
            chk("s_best",   32'(s_best), HS ? 32'(8'(to_bcd(ms.best))) : 32'h0);
            chk("s_display",32'(s_disp), (HS && m_s == 2'b11) ? 32'(8'(to_bcd(ms.best))) : 32'(8'(to_bcd(ms.count))));
            chk("s_running",32'(s_run),  32'(m_s == 2'b01 && m_d));
            chk("s_newbest",32'(s_nb),   32'(ms.nb));
            chk("s_overflow",32'(s_ovf), 32'(ms.ovf));
            if (nb)   nb_main++;
            if (s_nb) nb_sat++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (cnt == target) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Start with Delay already set, hold Start for 10n+5 cycles (exactly n ticks), then Finish
    task automatic run_and_finish(input int n);
        st = 2'b01; dl = 1'b1;
        cycles(10 * n + 5);
        st = 2'b10;
        cycles(4);
    endtask

    task automatic go_idle();
        st = 2'b00; dl = 1'b0;
        cycles(4);
    endtask

    int nb0, snb0;

    initial begin
        rst_n = 1'b0; st = 2'b00; dl = 1'b0;
        cycles(3);
        fork
            compare_loop();
        join_none
        @(negedge clk);
        chk("t1_rst_count", 32'(cnt), 32'h0);
        chk("t1_rst_best", 32'(best), 32'(BEST_INIT));
        rst_n = 1'b1;
        cycles(3);
        chk("t1_count", 32'(cnt), 32'h0000);
        chk("t1_best", 32'(best), 32'(BEST_INIT));
        chk("t1_running", 32'(run), 32'd0);
        chk("t1_display", 32'(disp), 32'h0000);

        // First run: 25 ticks becomes the best score
        nb0 = nb_main;
        run_and_finish(25);
        chk("t2_count", 32'(cnt), 32'h0025);
        chk("t2_best", 32'(best), HS ? 32'h0025 : 32'h0);
        chk("t2_newbest_pulses", 32'(nb_main - nb0), HS ? 32'd1 : 32'd0);
        go_idle();

        // Slower second run leaves best alone; High Score shows it
        nb0 = nb_main;
        run_and_finish(40);
        chk("t3_count", 32'(cnt), 32'h0040);
        chk("t3_best", 32'(best), HS ? 32'h0025 : 32'h0);
        chk("t3_newbest_pulses", 32'(nb_main - nb0), 32'd0);
        st = 2'b11;
        cycles(4);
        chk("t3_display_high", 32'(disp), HS ? 32'h0025 : 32'h0040);
        go_idle();

        // Saturation on the two-digit instance
        nb0 = nb_main; snb0 = nb_sat;
        st = 2'b01; dl = 1'b1;
        cycles(260);
        chk("t4_s_count_sat", 32'(s_cnt), 32'h99);
        chk("t4_s_overflow", 32'(s_ovf), 32'd1);
        st = 2'b10;
        cycles(4);
        chk("t4_s_count_hold", 32'(s_cnt), 32'h99);
        chk("t4_s_best", 32'(s_best), 32'(SBEST_INIT));
        chk("t4_s_newbest", 32'(nb_sat - snb0), 32'd0);
        chk("t4_main_newbest", 32'(nb_main - nb0), 32'd0);
        go_idle();

        // Carry ripple, overflow clear on new Start, Delay pause/resume
        nb0 = nb_main;
        st = 2'b01; dl = 1'b1;
        cycles(6);
        chk("t5_s_overflow_clr", 32'(s_ovf), 32'd0);
        wait_cnt(16'h0109, 1300, "t5_reach_0109");
        cycles(10);
        chk("t5_count_0110", 32'(cnt), 32'h0110);
        dl = 1'b0;
        cycles(30);
        chk("t5_pause_hold", 32'(cnt), 32'h0110);
        chk("t5_pause_running", 32'(run), 32'd0);
        dl = 1'b1;
        cycles(4);
        chk("t5_resume_running", 32'(run), 32'd1);
        st = 2'b10;
        cycles(4);
        chk("t5_best", 32'(best), HS ? 32'h0025 : 32'h0);
        chk("t5_newbest", 32'(nb_main - nb0), 32'd0);
        go_idle();

        // Reset mid-run, then an aborted run
        st = 2'b01; dl = 1'b1;
        wait_cnt(16'h0012, 300, "t6_reach_0012");
        rst_n = 1'b0;
        st = 2'b00; dl = 1'b0;
        @(negedge clk);
        chk("t6_rst_count", 32'(cnt), 32'h0000);
        chk("t6_rst_best", 32'(best), 32'(BEST_INIT));
        chk("t6_rst_running", 32'(run), 32'd0);
        chk("t6_rst_overflow", 32'(s_ovf), 32'd0);
        rst_n = 1'b1;
        cycles(3);
        nb0 = nb_main;
        st = 2'b01; dl = 1'b1;
        cycles(50);
        st = 2'b00;
        cycles(5);
        chk("t6_abort_count", 32'(cnt), 32'h0004);
        chk("t6_abort_best", 32'(best), 32'(BEST_INIT));
        chk("t6_abort_newbest", 32'(nb_main - nb0), 32'd0);
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
